imem_loader: RTL and testbench

- Program loader that writes the instruction memory read by the scalar MIPS pipeline's fetch stage.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Issues one write per word into the instruction-memory write port.
- Holds the pipeline in reset (core_reset) until a complete image has been loaded.

---
 rtl/imem_loader_pkg.sv | 32 +++
 rtl/imem_loader_if.sv | 27 ++
 rtl/imem_loader_byte_packer.sv | 48 ++++
 rtl/imem_loader.sv | 148 ++++++++++++++
 tb/tb_imem_loader.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg -- shared types and constants for the instruction-memory
// loader and its byte packer.
//   state_e      : loader FSM states (CHK exists only with the checksum build)
//   AFTER_LOAD   : state entered once the last word is packed (or N=0)
//   WORD_BYTES   : bytes per instruction word
//   LEN_BYTES    : bytes in the length header
//   INSTR_W      : instruction width shared with the pipeline fetch stage
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
package imem_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LEN_BYTES  = 2;
  localparam int INSTR_W    = 32;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, LOAD, CHK, DONE, ERR
  } state_e;
  localparam state_e AFTER_LOAD = CHK;
`else
  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, LOAD, DONE, ERR
  } state_e;
  localparam state_e AFTER_LOAD = DONE;
`endif

  // States in which a start request opens a new session.
  function automatic logic start_allowed(input state_e s);
    return (s == IDLE) || (s == DONE) || (s == ERR);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if -- byte-stream input and instruction-memory write port.
//   in_valid/in_data/in_ready : byte stream handshake (source -> loader)
//   imem_we/imem_addr/imem_wdata : one-cycle word write strobe (loader -> imem)
// Modports: master = loader side, slave = stream source / memory side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  import imem_loader_pkg::*;

  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;

  modport master (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// imem_loader_byte_packer -- assembles big-endian words from a byte stream.
//   clk, reset     : clock, async active-low reset
//   clear          : drop any partial word (new session)
//   byte_valid     : a byte is consumed this cycle
//   byte_data      : the byte
//   word_last      : combinational, this byte completes a word
//   word_valid     : registered one-cycle pulse after the completing byte
//   word           : assembled word, first byte in the MSBs
// Also used for the data-memory preload path.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               word_last,
  output logic               word_valid,
  output logic [INSTR_W-1:0] word
);

  logic [1:0]         cnt;
  logic [INSTR_W-1:0] sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      sr         <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        cnt <= '0;
        sr  <= '0;
      end else if (byte_valid) begin
        cnt        <= cnt + 2'd1;
        // Shifting left puts the first byte of a word at [31:24].
        sr         <= {sr[INSTR_W-9:0], byte_data};
        word_valid <= (cnt == 2'(WORD_BYTES - 1));
      end
    end
  end

  assign word_last = byte_valid && (cnt == 2'(WORD_BYTES - 1));
  assign word      = sr;

endmodule

// File: rtl/imem_loader.sv
// imem_loader -- loads a length-prefixed program image into instruction
// memory and holds the pipeline in reset until the image is complete.
//   clk, reset   : clock, async active-low reset
//   start        : open a session (honoured in IDLE/DONE/ERR only)
//   bus          : imem_loader_if.master (byte stream in, imem write out)
//   core_reset   : active-high pipeline reset, released one cycle into DONE
//   busy/done/error : session status
//   words_loaded : words written this session
// Stream format: N[15:8], N[7:0], then 4*N payload bytes (big-endian words).
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- a trailing byte must
// equal the XOR of all payload bytes, otherwise the session ends in ERR.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.master     bus,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  state_e             state_q, state_d;
  logic [15:0]        len_q;
  logic [15:0]        len_full;
  logic               accept;
  logic               start_ok;
  logic               load_byte;
  logic               last_word;
  logic               oversize;
  logic               pk_last, pk_valid;
  logic [INSTR_W-1:0] pk_word;
  logic               ready_c;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q;
`endif

  assign accept    = bus.in_valid && ready_c;
  assign start_ok  = start && start_allowed(state_q);
  assign load_byte = accept && (state_q == LOAD);
  // Header value as it stands on the edge that takes the low byte.
  assign len_full  = {len_q[15:8], bus.in_data};
  assign oversize  = 32'(len_full) > (32'd1 << ADDR_W);
  assign last_word = (32'(words_loaded) + 32'd1) == 32'(len_q);

  imem_loader_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_valid (load_byte),
    .byte_data  (bus.in_data),
    .word_last  (pk_last),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  assign bus.imem_we    = pk_valid;
  assign bus.imem_wdata = pk_word;
  assign bus.in_ready   = ready_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_c = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    error   = 1'b0;
    case (state_q)
      IDLE, ERR, DONE: begin
        done  = (state_q == DONE);
        error = (state_q == ERR);
        if (start) state_d = LEN_HI;
      end
      LEN_HI: begin
        ready_c = 1'b1;
        busy    = 1'b1;
        if (accept) state_d = LEN_LO;
      end
      LEN_LO: begin
        ready_c = 1'b1;
        busy    = 1'b1;
        if (accept) begin
          if (len_full == 16'd0) state_d = AFTER_LOAD;
          else if (oversize)     state_d = ERR;
          else                   state_d = LOAD;
        end
      end
      LOAD: begin
        ready_c = 1'b1;
        busy    = 1'b1;
        if (pk_last && last_word) state_d = AFTER_LOAD;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        ready_c = 1'b1;
        busy    = 1'b1;
        if (accept) state_d = (bus.in_data == csum_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q         <= '0;
      words_loaded  <= '0;
      bus.imem_addr <= '0;
      core_reset    <= 1'b1;
    end else begin
      // Released only once DONE has been held for a cycle, so the final
      // write lands while the core is still in reset; leaving DONE
      // reasserts it on the very next cycle.
      core_reset <= !((state_q == DONE) && (state_d == DONE));
      if (start_ok) begin
        len_q        <= '0;
        words_loaded <= '0;
      end
      if (accept && (state_q == LEN_HI)) len_q[15:8] <= bus.in_data;
      if (accept && (state_q == LEN_LO)) len_q[7:0]  <= bus.in_data;
      if (pk_last) begin
        // Word index wraps modulo the memory size.
        bus.imem_addr <= ADDR_W'(BASE_ADDR) + words_loaded[ADDR_W-1:0];
        words_loaded  <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         csum_q <= '0;
    else if (start_ok)  csum_q <= '0;
    else if (load_byte) csum_q <= csum_q ^ bus.in_data;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader -- self-checking bench for imem_loader: a table of sessions
// with hand-derived status, hand-written timing sequences, and randomized
// sessions checked against a behavioural model of the stream format.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W    = 8;
  localparam int BASE_ADDR = 0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic core_reset, busy, done, error;
  logic [ADDR_W:0] words_loaded;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus.master),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t got[$];
  wr_t exp_q[$];
  bit  exp_done, exp_err;
  int  exp_words;

  always @(negedge clk)
    if (bus.imem_we === 1'b1) got.push_back({bus.imem_addr, bus.imem_wdata});

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    int t;
    bus.in_valid = 1'b0;
    idle(gap);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (bus.in_ready !== 1'b1) begin
      if (t == 100) begin
        checks++;
        errors++;
        $display("FAIL send timeout: in_ready stuck low, byte %0h", b);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Behavioural model: what a session must produce given its stream.
  task automatic model(input logic [15:0] n, input logic [7:0] pay[$], input logic [7:0] trailer);
    logic [7:0] x;
    exp_q.delete();
    x = 8'h00;
    if (int'(n) > (1 << ADDR_W)) begin
      exp_done = 0; exp_err = 1; exp_words = 0;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      wr_t w;
      w.addr = ADDR_W'((BASE_ADDR + i) % (1 << ADDR_W));
      w.data = {pay[4*i], pay[4*i+1], pay[4*i+2], pay[4*i+3]};
      exp_q.push_back(w);
    end
    foreach (pay[i]) x ^= pay[i];
    exp_words = int'(n);
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_done = (trailer == x);
`else
    exp_done = 1'b1;
    if (trailer == x) exp_done = 1'b1;
`endif
    exp_err = !exp_done;
  endtask

  task automatic cmp_writes(input string name);
    chk({name, " nwr"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s wr%0d addr", name, i), 64'(got[i].addr), 64'(exp_q[i].addr));
      chk($sformatf("%s wr%0d data", name, i), 64'(got[i].data), 64'(exp_q[i].data));
    end
  endtask

  task automatic run(input string name, input logic [15:0] n, input logic [7:0] pay[$],
                     input logic [7:0] trailer, input int maxgap);
    got.delete();
    do_start();
    send(n[15:8], $urandom_range(0, maxgap));
    send(n[7:0],  $urandom_range(0, maxgap));
    if (int'(n) <= (1 << ADDR_W)) begin
      foreach (pay[i]) send(pay[i], $urandom_range(0, maxgap));
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(trailer, $urandom_range(0, maxgap));
`endif
    end
    idle(2);
    model(n, pay, trailer);
    chk({name, " done"}, done, exp_done);
    chk({name, " error"}, error, exp_err);
    chk({name, " words"}, words_loaded, exp_words);
    chk({name, " core_reset"}, core_reset, !exp_done);
    chk({name, " in_ready"}, bus.in_ready, 0);
    chk({name, " busy"}, busy, 0);
    cmp_writes(name);
  endtask

  function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  typedef struct {
    string       name;
    logic [15:0] n;
    bit          e_done;
    bit          e_err;
    int          e_words;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] pay[$];
    logic [15:0] n;
    logic [7:0] tr;

    tbl[0] = '{"two",     16'd2,     1, 0, 2};
    tbl[1] = '{"zero",    16'd0,     1, 0, 0};
    tbl[2] = '{"over257", 16'd257,   0, 1, 0};
    tbl[3] = '{"full256", 16'd256,   1, 0, 256};
    tbl[4] = '{"one",     16'd1,     1, 0, 1};
    tbl[5] = '{"maxlen",  16'hFFFF,  0, 1, 0};

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    idle(2);
    // Reset state
    chk("rst core_reset", core_reset, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst error", error, 0);
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst imem_we", bus.imem_we, 0);
    chk("rst words", words_loaded, 0);
    reset = 1'b1;
    idle(1);

    // Offered bytes in IDLE are neither taken nor change state.
    bus.in_valid = 1'b1; bus.in_data = 8'h55;
    idle(3);
    chk("idle ready", bus.in_ready, 0);
    chk("idle busy", busy, 0);
    chk("idle core_reset", core_reset, 1);
    bus.in_valid = 1'b0;

    // Two-word image with exact write and release timing.
    got.delete();
    do_start();
    chk("t1 busy", busy, 1);
    chk("t1 ready", bus.in_ready, 1);
    pay = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send(8'h00, 0); send(8'h02, 0);
    for (int i = 0; i < 4; i++) send(pay[i], 0);
    chk("t1 we0", bus.imem_we, 1);
    chk("t1 addr0", bus.imem_addr, 0);
    chk("t1 data0", bus.imem_wdata, 32'h12345678);
    chk("t1 words1", words_loaded, 1);
    for (int i = 4; i < 8; i++) send(pay[i], 0);
    chk("t1 we1", bus.imem_we, 1);
    chk("t1 addr1", bus.imem_addr, 1);
    chk("t1 data1", bus.imem_wdata, 32'h9ABCDEF0);
    chk("t1 words2", words_loaded, 2);
    chk("t1 core_reset during write", core_reset, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(xor_of(pay), 0);
    chk("t1 done", done, 1);
    idle(1);
`else
    chk("t1 done", done, 1);
    idle(1);
    chk("t1 we off", bus.imem_we, 0);
`endif
    chk("t1 core_reset released", core_reset, 0);
    model(16'd2, pay, xor_of(pay));
    cmp_writes("t1");

    // Restart from DONE reasserts core_reset next cycle; empty image.
    got.delete();
    do_start();
    chk("t2 core_reset", core_reset, 1);
    chk("t2 done cleared", done, 0);
    chk("t2 words cleared", words_loaded, 0);
    send(8'h00, 0); send(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t2 chk busy", busy, 1);
    send(8'h00, 0);
`endif
    idle(2);
    chk("t2 done", done, 1);
    chk("t2 core_reset", core_reset, 0);
    chk("t2 nwr", got.size(), 0);

    // Bursty valid and an ignored mid-session start.
    got.delete();
    do_start();
    send(8'h00, 1); send(8'h01, 1);
    send(8'hAA, 1);
    start = 1'b1; idle(1); start = 1'b0;
    send(8'hBB, 1); send(8'hCC, 1); send(8'hDD, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD, 1);
`endif
    idle(2);
    chk("t4 nwr", got.size(), 1);
    if (got.size() > 0) chk("t4 data", got[0].data, 32'hAABBCCDD);
    chk("t4 words", words_loaded, 1);
    chk("t4 done", done, 1);

    // Reset mid-session, then a fresh one-word image.
    do_start();
    send(8'h00, 0); send(8'h03, 0); send(8'hE1, 0); send(8'hE2, 0);
    reset = 1'b0;
    #1;
    chk("t5 core_reset", core_reset, 1);
    chk("t5 busy", busy, 0);
    chk("t5 ready", bus.in_ready, 0);
    chk("t5 words", words_loaded, 0);
    chk("t5 we", bus.imem_we, 0);
    chk("t5 done", done, 0);
    chk("t5 error", error, 0);
    idle(1);
    reset = 1'b1;
    idle(1);
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    run("t5b", 16'd1, pay, xor_of(pay), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pay = '{8'h01, 8'h02, 8'h03, 8'h04};
    run("t6 good", 16'd1, pay, 8'h04, 0);
    run("t6 bad", 16'd1, pay, 8'h05, 0);
    chk("t6 bad error", error, 1);
`endif

    // Table sessions, status against hand-derived constants and the model.
    foreach (tbl[k]) begin
      pay.delete();
      if (int'(tbl[k].n) <= (1 << ADDR_W))
        for (int i = 0; i < 4 * int'(tbl[k].n); i++) pay.push_back(8'($urandom_range(0, 255)));
      run(tbl[k].name, tbl[k].n, pay, xor_of(pay), (tbl[k].n > 16'd8) ? 0 : 2);
      chk({tbl[k].name, " tbl done"}, done, tbl[k].e_done);
      chk({tbl[k].name, " tbl error"}, error, tbl[k].e_err);
      chk({tbl[k].name, " tbl words"}, words_loaded, tbl[k].e_words);
    end

    // Randomized sessions.
    for (int s = 0; s < 25; s++) begin
      pay.delete();
      if ($urandom_range(0, 9) == 0) n = 16'($urandom_range(257, 65535));
      else                           n = 16'($urandom_range(0, 6));
      if (int'(n) <= (1 << ADDR_W))
        for (int i = 0; i < 4 * int'(n); i++) pay.push_back(8'($urandom_range(0, 255)));
      tr = xor_of(pay);
      if ($urandom_range(0, 3) == 0) tr = tr ^ 8'($urandom_range(1, 255));
      run($sformatf("rnd%0d", s), n, pay, tr, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
